// File: rtl/fir_coeff_loader_if.sv
// Bundle between the slow-control host, the loader and the FIR coefficient reload port.
interface fir_coeff_loader_if;
  logic        host_we;
  logic [1:0]  host_adr;
  logic [63:0] host_wdata;
  logic        start;
  logic [3:0]  filt_mask;
  logic        verify_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic        coeff_in_areset;
  logic [3:0]  coeff_in_we;
  logic [1:0]  coeff_in_adr;
  logic [63:0] coeff_in_data;
  logic        coeff_in_read;
  logic [3:0]  coeff_out_valid;
  logic [63:0] coeff_out_data;

  modport master (
    output host_we, host_adr, host_wdata, start, filt_mask, verify_en,
           coeff_out_valid, coeff_out_data,
    input  busy, done, err, err_code,
           coeff_in_areset, coeff_in_we, coeff_in_adr, coeff_in_data, coeff_in_read
  );

  modport slave (
    input  host_we, host_adr, host_wdata, start, filt_mask, verify_en,
           coeff_out_valid, coeff_out_data,
    output busy, done, err, err_code,
           coeff_in_areset, coeff_in_we, coeff_in_adr, coeff_in_data, coeff_in_read
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// Stages four coefficient words and reloads them into a masked set of FIR filters,
// with optional per-word readback compare.
module fir_coeff_loader #(
  parameter int ARESET_CYCLES = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              reset,
  fir_coeff_loader_if.slave bus
);
  localparam int NF   = 4;
  localparam int NW   = 4;
  localparam int DW   = 64;
  localparam int CMAX = (TIMEOUT > ARESET_CYCLES) ? TIMEOUT : ARESET_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, ARST, WRITE, RD_REQ, RD_WAIT, FIN} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   stg_q [NW];
  logic [NF-1:0]   mask_q, mask_d;
  logic            verify_q, verify_d;
  logic [1:0]      k_q, k_d, adr_q, adr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            zdone;
  logic [2:0]      first_f, next_f;

  logic            arst_q, arst_d, read_q, read_d, busy_q, busy_d, done_q, done_d;
  logic [NF-1:0]   we_q, we_d;
  logic [1:0]      cadr_q, cadr_d;
  logic [DW-1:0]   data_q, data_d;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [2:0] next_filt(input logic [NF-1:0] m, input int from);
    next_filt = 3'b000;
    for (int i = NF - 1; i >= 0; i--)
      if (i >= from && m[i]) next_filt = {1'b1, 2'(i)};
  endfunction

  assign first_f = next_filt(mask_q, 0);
  assign next_f  = next_filt(mask_q, int'(k_q) + 1);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    verify_d = verify_q;
    k_d      = k_q;
    adr_d    = adr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    code_d   = code_q;
    zdone    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        mask_d   = bus.filt_mask;
        verify_d = bus.verify_en;
        err_d    = 1'b0;
        code_d   = 2'd0;
        if (bus.filt_mask == '0) zdone = 1'b1;
        else begin
          state_d = ARST;
          cnt_d   = CW'(1);
        end
      end
      ARST: if (cnt_q >= CW'(ARESET_CYCLES)) begin
        state_d = WRITE;
        k_d     = first_f[1:0];
        adr_d   = 2'd0;
      end else cnt_d = cnt_q + 1'b1;
      WRITE: if (adr_q == 2'd3) begin
        adr_d = 2'd0;
        if (next_f[2]) k_d = next_f[1:0];
        else if (verify_q) begin
          state_d = RD_REQ;
          k_d     = first_f[1:0];
        end else state_d = FIN;
      end else adr_d = adr_q + 2'd1;
      RD_REQ: begin
        state_d = RD_WAIT;
        cnt_d   = CW'(1);
      end
      // Only the addressed filter's valid counts; a match advances, anything else aborts.
      RD_WAIT: if (bus.coeff_out_valid[k_q]) begin
        if (bus.coeff_out_data == stg_q[adr_q]) begin
          if (adr_q == 2'd3) begin
            adr_d = 2'd0;
            if (next_f[2]) begin
              k_d     = next_f[1:0];
              state_d = RD_REQ;
            end else state_d = FIN;
          end else begin
            adr_d   = adr_q + 2'd1;
            state_d = RD_REQ;
          end
        end else begin
          err_d   = 1'b1;
          code_d  = 2'd1;
          state_d = FIN;
        end
      end else if (cnt_q >= CW'(TIMEOUT)) begin
        err_d   = 1'b1;
        code_d  = 2'd2;
        state_d = FIN;
      end else cnt_d = cnt_q + 1'b1;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Filter-side outputs are registered from the next state so they line up with it.
  always_comb begin
    arst_d = (state_d == ARST);
    read_d = (state_d == RD_REQ);
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN) || zdone;
    we_d   = (state_d == WRITE) ? (4'b0001 << k_d) : 4'b0000;
    cadr_d = (state_d inside {WRITE, RD_REQ, RD_WAIT}) ? adr_d : 2'd0;
    data_d = (state_d == WRITE) ? stg_q[adr_d] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      verify_q <= 1'b0;
      k_q      <= 2'd0;
      adr_q    <= 2'd0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
      arst_q   <= 1'b0;
      read_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= '0;
      cadr_q   <= 2'd0;
      data_q   <= '0;
      for (int i = 0; i < NW; i++) stg_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      verify_q <= verify_d;
      k_q      <= k_d;
      adr_q    <= adr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      code_q   <= code_d;
      arst_q   <= arst_d;
      read_q   <= read_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      cadr_q   <= cadr_d;
      data_q   <= data_d;
      if (bus.host_we && state_q == IDLE) stg_q[bus.host_adr] <= bus.host_wdata;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.err             = err_q;
  assign bus.err_code        = code_q;
  assign bus.coeff_in_areset = arst_q;
  assign bus.coeff_in_we     = we_q;
  assign bus.coeff_in_adr    = cadr_q;
  assign bus.coeff_in_data   = data_q;
  assign bus.coeff_in_read   = read_q;
endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with a small echo model of the filter readback port.
module tb_fir_coeff_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_coeff_loader_if bus();
  fir_coeff_loader #(.ARESET_CYCLES(2), .TIMEOUT(255)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [63:0] W0 = 64'h1111111111111111;
  localparam logic [63:0] W1 = 64'h2222222222222222;
  localparam logic [63:0] W2 = 64'h3333333333333333;
  localparam logic [63:0] W3 = 64'h4444444444444444;
  localparam logic [63:0] X0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] X1 = 64'hFEDCBA9876543210;
  localparam logic [63:0] X2 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] X3 = 64'h5A5A5A5AA5A5A5A5;

  // Echo model: each filter remembers its writes; a read returns data 3 cycles later.
  logic        echo_en, corrupt_en;
  int          corrupt_f;
  logic [1:0]  corrupt_a;
  logic [3:0]  echo_mask;
  logic [63:0] mem [4][4];
  logic [1:0]  rp;
  logic [1:0]  ra0, ra1;
  int          rf0, rf1, rd_n;

  function automatic int nth_bit(input logic [3:0] m, input int n);
    int cnt = 0;
    nth_bit = 0;
    for (int i = 0; i < 4; i++)
      if (m[i]) begin
        if (cnt == n) nth_bit = i;
        cnt++;
      end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rp <= 2'b00; rd_n <= 0; ra0 <= 2'd0; ra1 <= 2'd0; rf0 <= 0; rf1 <= 0;
      bus.coeff_out_valid <= 4'b0; bus.coeff_out_data <= 64'h0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (bus.coeff_in_we[k]) mem[k][bus.coeff_in_adr] <= bus.coeff_in_data;
      rp   <= {rp[0], bus.coeff_in_read & echo_en};
      ra0  <= bus.coeff_in_adr; ra1 <= ra0;
      rf0  <= nth_bit(echo_mask, rd_n / 4); rf1 <= rf0;
      rd_n <= !bus.busy ? 0 : rd_n + (bus.coeff_in_read ? 1 : 0);
      bus.coeff_out_valid <= 4'b0;
      bus.coeff_out_data  <= 64'h0;
      if (rp[1]) begin
        bus.coeff_out_valid <= 4'b0001 << rf1;
        bus.coeff_out_data  <= mem[rf1][ra1] ^
          ((corrupt_en && rf1 == corrupt_f && ra1 == corrupt_a) ? 64'h1 : 64'h0);
      end
    end
  end

  // Per-cycle log of one sequence; index = cycles after the start cycle.
  logic [3:0]  we_l   [0:511];
  logic [1:0]  adr_l  [0:511];
  logic [63:0] data_l [0:511];
  logic        ar_l   [0:511];
  logic        rd_l   [0:511];
  logic        busy_l [0:511];
  logic        err_l  [0:511];
  logic [1:0]  code_l [0:511];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic stage(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
    logic [63:0] w [4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.host_we = 1'b1; bus.host_adr = 2'(i); bus.host_wdata = w[i];
      tick();
    end
    bus.host_we = 1'b0; bus.host_wdata = 64'h0;
  endtask

  // Pulses start, logs outputs each cycle until done (dc=-1 if it never comes).
  // At cycle icyc an ignored start/host_we is injected for one cycle.
  task automatic do_start(input logic [3:0] m, input logic v, input int maxc, input int icyc, output int dc);
    tick();
    bus.start = 1'b1; bus.filt_mask = m; bus.verify_en = v; echo_mask = m;
    tick();
    bus.start = 1'b0; bus.filt_mask = 4'h0; bus.verify_en = 1'b0;
    dc = -1;
    for (int c = 1; c <= maxc; c++) begin
      we_l[c] = bus.coeff_in_we; adr_l[c] = bus.coeff_in_adr; data_l[c] = bus.coeff_in_data;
      ar_l[c] = bus.coeff_in_areset; rd_l[c] = bus.coeff_in_read; busy_l[c] = bus.busy;
      err_l[c] = bus.err; code_l[c] = bus.err_code;
      if (bus.done) begin dc = c; break; end
      if (c == icyc) begin
        bus.start = 1'b1; bus.filt_mask = 4'hF; bus.verify_en = 1'b1;
        bus.host_we = 1'b1; bus.host_adr = 2'd0; bus.host_wdata = 64'hBAD0BAD0BAD0BAD0;
      end else if (c == icyc + 1) begin
        bus.start = 1'b0; bus.filt_mask = 4'h0; bus.verify_en = 1'b0;
        bus.host_we = 1'b0; bus.host_wdata = 64'h0;
      end
      tick();
    end
    bus.start = 1'b0; bus.host_we = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if ({bus.busy, bus.done, bus.err, bus.coeff_in_areset, bus.coeff_in_read} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl got %b exp 00000", {bus.busy, bus.done, bus.err, bus.coeff_in_areset, bus.coeff_in_read}); end
    n_chk++; if (bus.err_code !== 2'd0) begin n_fail++; $display("FAIL reset_code got %0d exp 0", bus.err_code); end
    n_chk++; if ({bus.coeff_in_we, bus.coeff_in_adr} !== 6'b0 || bus.coeff_in_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_bus we %b adr %0d data %h exp 0", bus.coeff_in_we, bus.coeff_in_adr, bus.coeff_in_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_all();
    int dc;
    stage(W0, W1, W2, W3);
    do_start(4'hF, 1'b0, 60, -1, dc);
    n_chk++; if (dc !== 19) begin n_fail++; $display("FAIL t1_done_cycle got %0d exp 19", dc); end
    n_chk++; if ({ar_l[1], ar_l[2], ar_l[3]} !== 3'b110) begin n_fail++; $display("FAIL t1_areset got %b exp 110", {ar_l[1], ar_l[2], ar_l[3]}); end
    n_chk++; if (we_l[1] !== 4'h0 || we_l[2] !== 4'h0) begin n_fail++; $display("FAIL t1_we_in_arst got %b %b exp 0", we_l[1], we_l[2]); end
    for (int c = 3; c <= 18; c++) begin
      logic [63:0] ew;
      ew = ((c - 3) % 4 == 0) ? W0 : ((c - 3) % 4 == 1) ? W1 : ((c - 3) % 4 == 2) ? W2 : W3;
      n_chk++;
      if (we_l[c] !== (4'b0001 << ((c - 3) / 4)) || adr_l[c] !== 2'((c - 3) % 4) || data_l[c] !== ew) begin
        n_fail++; $display("FAIL t1_write c=%0d got we %b adr %0d data %h exp we %b adr %0d data %h",
          c, we_l[c], adr_l[c], data_l[c], 4'b0001 << ((c - 3) / 4), (c - 3) % 4, ew);
      end
    end
    n_chk++; if (busy_l[19] !== 1'b1 || err_l[19] !== 1'b0) begin n_fail++; $display("FAIL t1_fin busy %b err %b exp 1 0", busy_l[19], err_l[19]); end
    tick();
    n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL t1_after busy %b done %b exp 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_verify_echo();
    int dc, nrd;
    stage(X0, X1, X2, X3);
    do_start(4'b0101, 1'b1, 100, -1, dc);
    n_chk++; if (dc !== 43) begin n_fail++; $display("FAIL t2_done_cycle got %0d exp 43", dc); end
    for (int c = 3; c <= 10; c++) begin
      n_chk++;
      if (we_l[c] !== ((c < 7) ? 4'b0001 : 4'b0100)) begin
        n_fail++; $display("FAIL t2_we c=%0d got %b exp %b", c, we_l[c], (c < 7) ? 4'b0001 : 4'b0100); end
    end
    nrd = 0;
    for (int c = 1; c <= 43; c++) if (rd_l[c] === 1'b1) nrd++;
    n_chk++; if (nrd !== 8) begin n_fail++; $display("FAIL t2_reads got %0d exp 8", nrd); end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (rd_l[11 + 4 * i] !== 1'b1 || adr_l[11 + 4 * i] !== 2'(i % 4) || adr_l[12 + 4 * i] !== 2'(i % 4)) begin
        n_fail++; $display("FAIL t2_read i=%0d got rd %b adr %0d hold %0d exp 1 %0d", i, rd_l[11 + 4 * i],
          adr_l[11 + 4 * i], adr_l[12 + 4 * i], i % 4); end
    end
    n_chk++; if (err_l[43] !== 1'b0 || code_l[43] !== 2'd0) begin n_fail++; $display("FAIL t2_err got %b %0d exp 0 0", err_l[43], code_l[43]); end
  endtask

  task automatic test_verify_mismatch();
    int dc, nrd;
    corrupt_en = 1'b1; corrupt_f = 2; corrupt_a = 2'd1;
    do_start(4'b0101, 1'b1, 100, -1, dc);
    corrupt_en = 1'b0;
    n_chk++; if (dc !== 35) begin n_fail++; $display("FAIL t3_done_cycle got %0d exp 35", dc); end
    nrd = 0;
    for (int c = 1; c <= 35; c++) if (rd_l[c] === 1'b1) nrd++;
    n_chk++; if (nrd !== 6) begin n_fail++; $display("FAIL t3_reads got %0d exp 6", nrd); end
    n_chk++; if (err_l[35] !== 1'b1 || code_l[35] !== 2'd1) begin n_fail++; $display("FAIL t3_err got %b %0d exp 1 1", err_l[35], code_l[35]); end
    tick(); tick();
    n_chk++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.coeff_in_read !== 1'b0) begin
      n_fail++; $display("FAIL t3_sticky err %b busy %b rd %b exp 1 0 0", bus.err, bus.busy, bus.coeff_in_read); end
  endtask

  task automatic test_verify_timeout();
    int dc, nrd;
    echo_en = 1'b0;
    do_start(4'b0001, 1'b1, 400, -1, dc);
    n_chk++; if (err_l[1] !== 1'b0 || code_l[1] !== 2'd0) begin n_fail++; $display("FAIL t4_err_clear got %b %0d exp 0 0", err_l[1], code_l[1]); end
    n_chk++; if (rd_l[7] !== 1'b1) begin n_fail++; $display("FAIL t4_rdreq got %b exp 1", rd_l[7]); end
    n_chk++; if (dc !== 263) begin n_fail++; $display("FAIL t4_done_cycle got %0d exp 263", dc); end
    nrd = 0;
    for (int c = 1; c <= 263; c++) if (rd_l[c] === 1'b1) nrd++;
    n_chk++; if (nrd !== 1) begin n_fail++; $display("FAIL t4_reads got %0d exp 1", nrd); end
    n_chk++; if (err_l[263] !== 1'b1 || code_l[263] !== 2'd2) begin n_fail++; $display("FAIL t4_err got %b %0d exp 1 2", err_l[263], code_l[263]); end
    tick();
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL t4_busy_fall got %b exp 0", bus.busy); end
    echo_en = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    int dc;
    stage(W0, W1, W2, W3);
    bus.start = 1'b1; bus.filt_mask = 4'hF; bus.verify_en = 1'b0; echo_mask = 4'hF;
    tick();
    bus.start = 1'b0; bus.filt_mask = 4'h0;
    repeat (7) tick();
    n_chk++; if (bus.coeff_in_we !== 4'b0010) begin n_fail++; $display("FAIL t5_mid_we got %b exp 0010", bus.coeff_in_we); end
    reset = 1'b1;
    #1;
    n_chk++; if (bus.coeff_in_we !== 4'h0 || bus.coeff_in_areset !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL t5_async we %b arst %b busy %b exp 0", bus.coeff_in_we, bus.coeff_in_areset, bus.busy); end
    #2;
    reset = 1'b0;
    do_start(4'h0, 1'b0, 5, -1, dc);
    n_chk++; if (dc !== 1) begin n_fail++; $display("FAIL t5_zero_done got %0d exp 1", dc); end
    n_chk++; if (busy_l[1] !== 1'b0 || we_l[1] !== 4'h0 || ar_l[1] !== 1'b0) begin
      n_fail++; $display("FAIL t5_zero_quiet busy %b we %b arst %b exp 0", busy_l[1], we_l[1], ar_l[1]); end
    do_start(4'b0001, 1'b0, 50, -1, dc);
    n_chk++; if (dc !== 7) begin n_fail++; $display("FAIL t5_one_done got %0d exp 7", dc); end
    for (int c = 3; c <= 6; c++) begin
      n_chk++; if (we_l[c] !== 4'b0001 || data_l[c] !== 64'h0) begin
        n_fail++; $display("FAIL t5_cleared c=%0d we %b data %h exp 0001 0", c, we_l[c], data_l[c]); end
    end
  endtask

  task automatic test_busy_ignore();
    int dc;
    stage(W0, W1, W2, W3);
    do_start(4'b0010, 1'b0, 50, 2, dc);
    n_chk++; if (dc !== 7) begin n_fail++; $display("FAIL t6_done_cycle got %0d exp 7", dc); end
    for (int c = 3; c <= 6; c++) begin
      logic [63:0] ew;
      ew = (c == 3) ? W0 : (c == 4) ? W1 : (c == 5) ? W2 : W3;
      n_chk++; if (we_l[c] !== 4'b0010 || data_l[c] !== ew) begin
        n_fail++; $display("FAIL t6_write c=%0d we %b data %h exp 0010 %h", c, we_l[c], data_l[c], ew); end
    end
    tick(); tick();
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL t6_no_restart busy %b exp 0", bus.busy); end
    do_start(4'b0001, 1'b0, 50, -1, dc);
    n_chk++; if (data_l[3] !== W0) begin n_fail++; $display("FAIL t6_staging got %h exp %h", data_l[3], W0); end
  endtask

  initial begin
    reset = 1'b1;
    bus.host_we = 1'b0; bus.host_adr = 2'd0; bus.host_wdata = 64'h0;
    bus.start = 1'b0; bus.filt_mask = 4'h0; bus.verify_en = 1'b0;
    echo_en = 1'b1; corrupt_en = 1'b0; corrupt_f = 0; corrupt_a = 2'd0; echo_mask = 4'h0;
    tick(); tick();
    test_reset();
    test_load_all();
    test_verify_echo();
    test_verify_mismatch();
    test_verify_timeout();
    test_reset_mid_write();
    test_busy_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
